seg_scan_mux: RTL

//   Parametrised time-multiplexed driver for common-anode 7-segment banks of up to 8 digits.

---
 rtl/seg_scan_mux.sv | 123 ++++++++++++
 1 files changed

// File: rtl/seg_scan_mux.sv
// Time-multiplexed common-anode 7-segment scanner; outputs are Moore-decoded from registers (no latency beyond the scan itself), no backpressure.
// Optional SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits of the frame snapshot (digit 0 always shown).
module seg_scan_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp,
  output logic [6:0]              cathode,
  output logic                    dp_n,
  output logic [7:0]              anode
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] snap_value;
  logic [NUM_DIGITS-1:0]   snap_en;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic                    load_pend;
  logic                    slot_end;
  logic                    frame_end;
  logic                    in_blank;
  logic                    suppress;
  logic [3:0]              nibble;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      idx        <= '0;
      snap_value <= '0;
      snap_en    <= '0;
      snap_dp    <= '0;
      load_pend  <= 1'b1;
    end else begin
      load_pend <= 1'b0;
      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // Capture on the last cycle of a frame so the next frame shows one coherent value
      if (load_pend || frame_end) begin
        snap_value <= value;
        snap_en    <= digit_en;
        snap_dp    <= dp;
      end
    end
  end

  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (cnt < CW'(BLANK_CYCLES));
    end
  endgenerate

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  lz_run;

  always_comb begin
    lz_mask = '0;
    lz_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (snap_value[4*i +: 4] != 4'h0) lz_run = 1'b0;
      lz_mask[i] = lz_run;
    end
  end

  assign suppress = lz_mask[idx];
`else
  assign suppress = 1'b0;
`endif

  assign nibble = snap_value[4*idx +: 4];

  always_comb begin
    anode   = 8'hFF;
    cathode = 7'h7F;
    dp_n    = 1'b1;
    if (!in_blank && snap_en[idx]) begin
      anode   = ~(8'b1 << idx);
      cathode = suppress ? 7'h7F : hex7(nibble);
      dp_n    = ~snap_dp[idx];
    end
  end

endmodule
